// File: rtl/vault_work_dispatcher.sv
// Work dispatcher for a bank of mining cores: broadcasts work, collects found
// nonces through per-core pending slots into a result FIFO, and measures hashrate.
module vault_work_dispatcher #(
  parameter int unsigned NUM_CORES   = 4,
  parameter int unsigned WORK_W      = 640,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned RATE_WINDOW = 100000000,
  parameter int unsigned LED_THRESH  = 40000000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      work_valid,
  output logic                      work_ready,
  input  logic [WORK_W-1:0]         work_data,
  output logic [WORK_W-1:0]         core_work,
  output logic [NUM_CORES-1:0]      core_start,
  output logic                      core_abort,
  output logic [NUM_CORES*32-1:0]   core_base_nonce,
  input  logic [NUM_CORES-1:0]      core_busy,
  input  logic [NUM_CORES-1:0]      core_found,
  input  logic [NUM_CORES-1:0]      core_hash_tick,
  input  logic [NUM_CORES*32-1:0]   core_nonce,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [31:0]               res_nonce,
  output logic [((NUM_CORES > 1) ? $clog2(NUM_CORES) : 1)-1:0] res_core,
  output logic [31:0]               hashrate,
  output logic                      overflow,
  output logic [1:0]                state,
  output logic [3:0]                leds
);

  localparam int unsigned RC_W   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CYC_W  = (RATE_WINDOW > 1) ? $clog2(RATE_WINDOW) : 1;
  localparam int unsigned TICK_W = $clog2(NUM_CORES + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_ABORT = 2'd3
  } state_e;

  typedef struct packed {
    logic [RC_W-1:0] core;
    logic [31:0]     nonce;
  } res_entry_t;

  state_e                state_q, state_d;
  logic [WORK_W-1:0]     work_q, work_d;
  logic [NUM_CORES-1:0]  start_q, start_d;
  logic                  abort_q, abort_d;
  logic [1:0]            run_cnt_q, run_cnt_d;
  logic                  xfer;

  logic [NUM_CORES-1:0]  pend_v_q, pend_v_d;
  logic [31:0]           pend_n_q [NUM_CORES];
  logic [31:0]           pend_n_d [NUM_CORES];
  logic                  ovf_q, ovf_d;
  logic                  push_any, push;
  logic [RC_W-1:0]       sel;
  res_entry_t            push_entry;

  res_entry_t            mem_q [FIFO_DEPTH];
  logic [PTR_W:0]        wr_q, rd_q;
  logic                  full, empty, pop;

  logic [TICK_W-1:0]     tick_cnt;
  logic [32:0]           win_sum;
  logic [31:0]           win_sat;
  logic [31:0]           win_q, rate_q;
  logic [CYC_W-1:0]      cyc_q;
  logic                  window_end;
  logic                  any_push_q;

  assign work_ready = enable && (state_q == ST_IDLE || state_q == ST_RUN);
  assign xfer       = work_valid && work_ready;

  // Control FSM next-state; a new transfer in RUN restarts the job through LOAD.
  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    start_d   = '0;
    abort_d   = 1'b0;
    run_cnt_d = run_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          work_d  = work_data;
          start_d = '1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        run_cnt_d = 2'd1;
        if (!enable) begin
          abort_d = 1'b1;
          state_d = ST_ABORT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          abort_d = 1'b1;
          state_d = ST_ABORT;
        end else if (xfer) begin
          work_d  = work_data;
          start_d = '1;
          state_d = ST_LOAD;
        end else begin
          if (run_cnt_q != 2'd3) run_cnt_d = run_cnt_q + 2'd1;
          if (core_busy == '0 && run_cnt_q >= 2'd2) state_d = ST_IDLE;
        end
      end
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      work_q    <= '0;
      start_q   <= '0;
      abort_q   <= 1'b0;
      run_cnt_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      start_q   <= start_d;
      abort_q   <= abort_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  assign state      = state_q;
  assign core_work  = work_q;
  assign core_start = start_q;
  assign core_abort = abort_q;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_base
    assign core_base_nonce[32*g +: 32] = 32'((64'(g) << 32) / 64'(NUM_CORES));
  end

  // Lowest occupied pending slot drains first; a slot freed this cycle may reload.
  always_comb begin
    push_any = 1'b0;
    sel      = '0;
    for (int i = int'(NUM_CORES) - 1; i >= 0; i--) begin
      if (pend_v_q[i]) begin
        push_any = 1'b1;
        sel      = RC_W'(i);
      end
    end
    push       = push_any && (!full || pop);
    push_entry = '{core: sel, nonce: pend_n_q[sel]};
    pend_v_d   = pend_v_q;
    pend_n_d   = pend_n_q;
    ovf_d      = ovf_q;
    if (push) pend_v_d[sel] = 1'b0;
    for (int i = 0; i < int'(NUM_CORES); i++) begin
      if (core_found[i]) begin
        if (!pend_v_d[i]) begin
          pend_v_d[i] = 1'b1;
          pend_n_d[i] = core_nonce[32*i +: 32];
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v_q   <= '0;
      ovf_q      <= 1'b0;
      any_push_q <= 1'b0;
      for (int i = 0; i < int'(NUM_CORES); i++) pend_n_q[i] <= '0;
    end else begin
      pend_v_q   <= pend_v_d;
      ovf_q      <= ovf_d;
      any_push_q <= any_push_q | push;
      pend_n_q   <= pend_n_d;
    end
  end

  assign full  = (wr_q - rd_q) == (PTR_W+1)'(FIFO_DEPTH);
  assign empty = (wr_q == rd_q);
  assign pop   = !empty && res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + (PTR_W+1)'(1);
      if (pop)  rd_q <= rd_q + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[PTR_W-1:0]] <= push_entry;
  end

  assign res_valid = !empty;
  assign res_nonce = mem_q[rd_q[PTR_W-1:0]].nonce;
  assign res_core  = mem_q[rd_q[PTR_W-1:0]].core;
  assign overflow  = ovf_q;

  // Hash tick accumulation with saturation; the closing cycle's ticks count.
  always_comb begin
    tick_cnt = '0;
    for (int i = 0; i < int'(NUM_CORES); i++) tick_cnt = tick_cnt + TICK_W'(core_hash_tick[i]);
    win_sum = {1'b0, win_q} + 33'(tick_cnt);
    win_sat = win_sum[32] ? 32'hFFFF_FFFF : win_sum[31:0];
  end

  assign window_end = (cyc_q == CYC_W'(RATE_WINDOW - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q  <= '0;
      rate_q <= '0;
      cyc_q  <= '0;
    end else if (window_end) begin
      rate_q <= win_sat;
      win_q  <= '0;
      cyc_q  <= '0;
    end else begin
      win_q  <= win_sat;
      cyc_q  <= cyc_q + CYC_W'(1);
    end
  end

  assign hashrate = rate_q;
  assign leds     = {state_q == ST_RUN, any_push_q, rate_q > 32'(LED_THRESH), enable};

endmodule

// File: tb/tb_vault_work_dispatcher.sv
// Self-checking bench for vault_work_dispatcher: scenario tasks with a result scoreboard.
module tb_vault_work_dispatcher;

  localparam int unsigned NC = 4;
  localparam int unsigned WW = 64;

  typedef struct packed {
    logic [1:0]  core;
    logic [31:0] nonce;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n, enable, work_valid, work_ready;
  logic [WW-1:0]   work_data, core_work;
  logic [NC-1:0]   core_start, core_busy, core_found, core_hash_tick;
  logic            core_abort;
  logic [NC*32-1:0] core_base_nonce, core_nonce;
  logic            res_valid, res_ready, overflow;
  logic [31:0]     res_nonce, hashrate;
  logic [1:0]      res_core, state;
  logic [3:0]      leds;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];
  exp_t e;

  vault_work_dispatcher #(
    .NUM_CORES(NC), .WORK_W(WW), .FIFO_DEPTH(8), .RATE_WINDOW(10), .LED_THRESH(39)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .work_valid(work_valid), .work_ready(work_ready), .work_data(work_data),
    .core_work(core_work), .core_start(core_start), .core_abort(core_abort),
    .core_base_nonce(core_base_nonce), .core_busy(core_busy), .core_found(core_found),
    .core_hash_tick(core_hash_tick), .core_nonce(core_nonce),
    .res_valid(res_valid), .res_ready(res_ready), .res_nonce(res_nonce), .res_core(res_core),
    .hashrate(hashrate), .overflow(overflow), .state(state), .leds(leds)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; work_valid = 1'b0; work_data = '0; core_busy = '0;
    core_found = '0; core_hash_tick = '0; core_nonce = '0; res_ready = 1'b0;
    repeat (3) step();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if (core_start !== 4'h0 || core_abort !== 1'b0) begin errors++; $display("FAIL reset_pulses: start=%h abort=%b want 0", core_start, core_abort); end
    checks++; if (overflow !== 1'b0 || hashrate !== 32'd0) begin errors++; $display("FAIL reset_stat: ovf=%b rate=%0d want 0", overflow, hashrate); end
    checks++; if (res_valid !== 1'b0 || leds[2] !== 1'b0) begin errors++; $display("FAIL reset_res: valid=%b led2=%b want 0", res_valid, leds[2]); end
    checks++; if (core_work !== '0) begin errors++; $display("FAIL reset_work: got %h want 0", core_work); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_load();
    logic [31:0] exp_base;
    work_valid = 1'b1; work_data = 64'hDEAD_BEEF_0123_4567;
    checks++; if (work_ready !== 1'b1) begin errors++; $display("FAIL load_ready: got %b want 1", work_ready); end
    step();
    work_valid = 1'b0; core_busy = 4'hF;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL load_state: got %0d want 1", state); end
    checks++; if (core_start !== 4'hF) begin errors++; $display("FAIL load_start: got %h want f", core_start); end
    checks++; if (core_work !== 64'hDEAD_BEEF_0123_4567) begin errors++; $display("FAIL load_work: got %h", core_work); end
    step();
    checks++; if (state !== 2'd2 || core_start !== 4'h0) begin errors++; $display("FAIL load_run: state=%0d start=%h want 2/0", state, core_start); end
    checks++; if (leds[3] !== 1'b1) begin errors++; $display("FAIL load_led3: got %b want 1", leds[3]); end
    for (int i = 0; i < 4; i++) begin
      exp_base = 32'(i) * 32'h4000_0000;
      checks++; if (core_base_nonce[32*i +: 32] !== exp_base) begin errors++; $display("FAIL base_%0d: got %h want %h", i, core_base_nonce[32*i +: 32], exp_base); end
    end
  endtask

  task automatic test_order();
    int first_c, got;
    first_c = -1; got = 0;
    res_ready = 1'b1;
    core_found = 4'b1010;
    core_nonce[32*1 +: 32] = 32'h11; core_nonce[32*3 +: 32] = 32'h33;
    sb_q.push_back('{core: 2'd1, nonce: 32'h11});
    sb_q.push_back('{core: 2'd3, nonce: 32'h33});
    step();
    core_found = '0;
    for (int c = 0; c < 20 && sb_q.size() > 0; c++) begin
      if (res_valid) begin
        e = sb_q.pop_front();
        checks++; if (res_core !== e.core || res_nonce !== e.nonce) begin errors++; $display("FAIL order_entry: got %0d/%h want %0d/%h", res_core, res_nonce, e.core, e.nonce); end
        if (got == 1) begin
          checks++; if (c - first_c != 1) begin errors++; $display("FAIL order_consec: gap %0d want 1", c - first_c); end
        end
        first_c = c; got++;
      end
      step();
    end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL order_timeout: %0d left want 0", sb_q.size()); sb_q.delete(); end
    checks++; if (overflow !== 1'b0 || leds[2] !== 1'b1) begin errors++; $display("FAIL order_flags: ovf=%b led2=%b want 0/1", overflow, leds[2]); end
  endtask

  task automatic test_overflow();
    res_ready = 1'b0;
    for (int j = 0; j < 8; j++) begin
      core_found = 4'b0100; core_nonce[32*2 +: 32] = 32'h200 + 32'(j);
      sb_q.push_back('{core: 2'd2, nonce: 32'h200 + 32'(j)});
      step();
    end
    core_found = '0;
    step();
    core_found = 4'b0001; core_nonce[31:0] = 32'hAAAA_0001;
    sb_q.push_back('{core: 2'd0, nonce: 32'hAAAA_0001});
    step();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_first_held: got %b want 0", overflow); end
    core_nonce[31:0] = 32'hBBBB_0002;
    step();
    core_found = '0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_second: got %b want 1", overflow); end
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %b want 1", res_valid); end
    res_ready = 1'b1;
    for (int c = 0; c < 40 && sb_q.size() > 0; c++) begin
      if (res_valid) begin
        e = sb_q.pop_front();
        checks++; if (res_core !== e.core || res_nonce !== e.nonce) begin errors++; $display("FAIL ovf_entry: got %0d/%h want %0d/%h", res_core, res_nonce, e.core, e.nonce); end
      end
      step();
    end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL ovf_timeout: %0d left want 0", sb_q.size()); sb_q.delete(); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained: valid=%b want 0", res_valid); end
  endtask

  task automatic test_abort();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL abort_pre: state=%0d want 2", state); end
    enable = 1'b0;
    #1;
    checks++; if (work_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b want 0", work_ready); end
    step();
    checks++; if (state !== 2'd3 || core_abort !== 1'b1) begin errors++; $display("FAIL abort_pulse: state=%0d abort=%b want 3/1", state, core_abort); end
    step();
    checks++; if (state !== 2'd0 || core_abort !== 1'b0) begin errors++; $display("FAIL abort_idle: state=%0d abort=%b want 0/0", state, core_abort); end
    work_valid = 1'b1;
    repeat (3) begin
      step();
      checks++; if (state !== 2'd0 || core_abort !== 1'b0 || work_ready !== 1'b0) begin errors++; $display("FAIL abort_hold: state=%0d abort=%b ready=%b want 0/0/0", state, core_abort, work_ready); end
    end
    work_valid = 1'b0; enable = 1'b1;
    step();
  endtask

  task automatic test_run_done();
    int reached;
    work_valid = 1'b1; work_data = 64'h1111; core_busy = 4'hF;
    step();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL rd_load: state=%0d want 1", state); end
    work_valid = 1'b0;
    step();
    work_valid = 1'b1; work_data = 64'h2222;
    step();
    work_valid = 1'b0; core_busy = 4'h0;
    checks++; if (state !== 2'd1 || core_work !== 64'h2222 || core_start !== 4'hF) begin errors++; $display("FAIL rd_preempt: state=%0d work=%h start=%h", state, core_work, core_start); end
    step();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL rd_run: state=%0d want 2", state); end
    reached = 0;
    for (int c = 0; c < 5 && reached == 0; c++) begin
      step();
      if (state == 2'd0) reached = 1;
    end
    checks++; if (reached != 1) begin errors++; $display("FAIL rd_idle: state=%0d want 0 within 5 cycles", state); end
  endtask

  task automatic test_hashrate();
    core_hash_tick = 4'hF;
    repeat (25) step();
    checks++; if (hashrate !== 32'd40 || leds[1] !== 1'b1) begin errors++; $display("FAIL rate_a: got %0d led1=%b want 40/1", hashrate, leds[1]); end
    repeat (10) step();
    checks++; if (hashrate !== 32'd40) begin errors++; $display("FAIL rate_b: got %0d want 40", hashrate); end
    core_hash_tick = 4'h0;
    repeat (25) step();
    checks++; if (hashrate !== 32'd0 || leds[1] !== 1'b0) begin errors++; $display("FAIL rate_zero: got %0d led1=%b want 0/0", hashrate, leds[1]); end
  endtask

  task automatic test_reset_mid_run();
    work_valid = 1'b1; work_data = 64'h3333; core_busy = 4'hF; res_ready = 1'b0;
    step();
    work_valid = 1'b0;
    step();
    core_found = 4'b0010; core_nonce[32*1 +: 32] = 32'h77;
    step();
    core_found = '0;
    step(); step();
    checks++; if (state !== 2'd2 || res_valid !== 1'b1) begin errors++; $display("FAIL rmr_pre: state=%0d valid=%b want 2/1", state, res_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (state !== 2'd0 || res_valid !== 1'b0) begin errors++; $display("FAIL rmr_async: state=%0d valid=%b want 0/0", state, res_valid); end
    repeat (3) begin
      step();
      checks++; if (core_abort !== 1'b0) begin errors++; $display("FAIL rmr_abort_in_rst: got %b want 0", core_abort); end
    end
    rst_n = 1'b1;
    repeat (3) begin
      step();
      checks++; if (core_abort !== 1'b0 || state !== 2'd0) begin errors++; $display("FAIL rmr_after: abort=%b state=%0d want 0/0", core_abort, state); end
    end
    checks++; if (overflow !== 1'b0 || leds[2] !== 1'b0 || core_work !== '0 || hashrate !== 32'd0) begin errors++; $display("FAIL rmr_clear: ovf=%b led2=%b work=%h rate=%0d", overflow, leds[2], core_work, hashrate); end
    work_valid = 1'b1; work_data = 64'h4444;
    step();
    work_valid = 1'b0;
    checks++; if (state !== 2'd1 || core_start !== 4'hF || core_work !== 64'h4444) begin errors++; $display("FAIL rmr_reload: state=%0d start=%h work=%h", state, core_start, core_work); end
    step();
    checks++; if (state !== 2'd2 || res_valid !== 1'b0) begin errors++; $display("FAIL rmr_run: state=%0d valid=%b want 2/0", state, res_valid); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_order();
    test_overflow();
    test_abort();
    test_run_done();
    test_hashrate();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vault_work_dispatcher.md
VAULT_WORK_DISPATCHER -- requirements
Module: vault_work_dispatcher

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, number of mining cores served; power of two, 1..16.
REQ-002 SHALL have parameter WORK_W, default 640, width of one work package in bits.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, result FIFO entries; power of two, at least 2.
REQ-004 SHALL have parameter RATE_WINDOW, default 100000000, hashrate sampling window in clk cycles.
REQ-005 SHALL have parameter LED_THRESH, default 40000000, hashrate threshold for the activity LED.
REQ-006 SHALL have these ports: clk  in  1  single system clock; all logic is on its rising edge.
REQ-007 SHALL have: rst_n  in  1  asynchronous, active-low reset.
REQ-008 SHALL have: enable  in  1  golden-identity gate; low forces IDLE.
REQ-009 SHALL have: work_valid  in  1; work_ready  out  1; work_data  in  WORK_W — work handshake.
REQ-010 SHALL have: core_work  out  WORK_W  latched work, broadcast to all cores.
REQ-011 SHALL have: core_start  out  NUM_CORES; core_abort  out  1  — one-cycle pulses.
REQ-012 SHALL have: core_base_nonce  out  NUM_CORES*32  per-core starting nonce; core i uses bits [32i+31:32i].
REQ-013 SHALL have: core_busy, core_found, core_hash_tick  in  NUM_CORES each; core_nonce  in  NUM_CORES*32.
REQ-014 SHALL have: res_valid  out  1; res_ready  in  1; res_nonce  out  32; res_core  out  $clog2(NUM_CORES) or 1 — result handshake.
REQ-015 SHALL have: hashrate  out  32; overflow  out  1; state  out  2; leds  out  4.

Function
REQ-016 SHALL implement FSM IDLE=0, LOAD=1, RUN=2, ABORT=3, visible on state.
REQ-017 work_ready SHALL be 1 exactly when enable=1 and state is IDLE or RUN; a transfer occurs on work_valid & work_ready.
REQ-018 On a transfer, SHALL latch work_data into core_work and go to LOAD; a transfer in RUN preempts the current job.
REQ-019 LOAD SHALL last exactly 1 cycle, drive core_start to all ones, and go to RUN.
REQ-020 core_base_nonce[i] SHALL equal i * (2^32 / NUM_CORES), constant, giving disjoint equal nonce ranges.
REQ-021 RUN SHALL go to IDLE when core_busy == 0 and at least 2 cycles have elapsed since LOAD.
REQ-022 enable=0 in LOAD or RUN SHALL go to ABORT; ABORT SHALL pulse core_abort for 1 cycle, then go to IDLE.
REQ-023 enable=0 in IDLE SHALL keep IDLE with no core_abort pulse.
REQ-024 Each core SHALL have a 1-entry pending register; core_found[i] loads core_nonce[i] into pending[i].
REQ-025 A found pulse on a core whose pending register is occupied, and not vacated that cycle, SHALL be dropped and set overflow (sticky until reset).
REQ-026 Each cycle, at most one pending entry SHALL be pushed to the result FIFO, when the FIFO is not full, choosing the lowest occupied core index.
REQ-027 When the FIFO is full, pending entries SHALL be held and no data lost until a pending register is re-hit.
REQ-028 A push and a pop in the same cycle on a full FIFO SHALL both succeed.
REQ-029 res_valid SHALL equal FIFO not empty; the FIFO pops on res_valid & res_ready; res_nonce and res_core show the head entry, first-word-fall-through.
REQ-030 Pending registers and the FIFO SHALL survive ABORT and preemption.
REQ-031 Each cycle, the popcount of core_hash_tick SHALL be added to a window counter, saturating at 2^32-1.
REQ-032 After every RATE_WINDOW cycles, hashrate SHALL take the counter value (including that cycle's ticks) and the counter SHALL restart at 0.
REQ-033 leds SHALL be: [0]=enable, [1]=(hashrate > LED_THRESH), [2]=sticky "any result pushed since reset", [3]=(state==RUN).

Reset
REQ-034 rst_n low SHALL immediately clear state to IDLE and clear core_start, core_abort, overflow, hashrate, the window counter, pending registers, FIFO pointers, leds[2], and core_work to 0.
REQ-035 A reset in mid-RUN SHALL NOT pulse core_abort; the first accepted transfer after release SHALL behave as from power-up.

Verification
REQ-036 Bench SHALL cover: NUM_CORES=4, enable=1, a work transfer → LOAD next cycle, core_start=4'b1111 for 1 cycle, bases 0x00000000/0x40000000/0x80000000/0xC00000000>>4, i.e. 0xC0000000.
REQ-037 Bench SHALL cover: cores 1 and 3 found together, nonces 0x11 and 0x33 → FIFO order core 1 then core 3 on consecutive cycles; overflow=0.
REQ-038 Bench SHALL cover: res_ready=0 until FIFO holds 8 entries, then core 0 found twice → first held pending, second sets overflow=1; the 9th result appears after 1 pop.
REQ-039 Bench SHALL cover: enable dropped in RUN → ABORT, core_abort=1 for exactly 1 cycle, IDLE next, work_ready=0 while enable=0.
REQ-040 Bench SHALL cover: RATE_WINDOW=10, all 4 ticks high continuously → hashrate=40 after each window; with LED_THRESH=39, leds[1]=1.
REQ-041 Bench SHALL cover: rst_n asserted mid-RUN with a non-empty FIFO → state=0, res_valid=0, core_abort never pulses.
